// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module : otter_cu_fsm
// Multicycle fetch/execute/writeback sequencer for the OTTER RV32I core;
// issues PC, register-file, memory and CSR strobes and counts retirements.
// Rev    : 1.0
// ============================================================================
module otter_cu_fsm #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       ir6_0,
    input  logic [2:0]       ir14_12,
    input  logic             intr,
    input  logic             csr_mie,
    output logic             pcWrite,
    output logic             regWrite,
    output logic             memWE2,
    output logic             memRDEN1,
    output logic             memRDEN2,
    output logic             rst,
    output logic             csr_WE,
    output logic             int_taken,
    output logic             mret_exec,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [2:0] c_f3_mret   = 3'b000;
    localparam logic [2:0] c_f3_csrrw  = 3'b001;
    localparam logic [3:0] c_wait_load = 4'(MEM_LAT - 1);

    state_t           r_state;
    logic [3:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_instret;
    logic             w_complete;
    logic             w_irq;

    assign w_irq   = intr & csr_mie;
    assign instret = r_instret;

    always_comb begin
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        memWE2     = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        rst        = 1'b0;
        csr_WE     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            ST_INIT:  rst      = 1'b1;
            ST_FETCH: memRDEN1 = 1'b1;
            ST_EXEC: begin
                // Every non-load retires here; unknown encodings behave as a NOP.
                pcWrite    = 1'b1;
                w_complete = 1'b1;
                case (ir6_0)
                    c_op_load: begin
                        memRDEN2   = 1'b1;
                        pcWrite    = 1'b0;
                        w_complete = 1'b0;
                    end
                    c_op_store:  memWE2 = 1'b1;
                    c_op_branch: begin end
                    c_op_rtype, c_op_itype, c_op_lui,
                    c_op_auipc, c_op_jal, c_op_jalr: regWrite = 1'b1;
                    c_op_system: begin
                        if (ir14_12 == c_f3_csrrw) begin
                            csr_WE   = 1'b1;
                            regWrite = 1'b1;
                        end else if (ir14_12 == c_f3_mret) begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin end
                endcase
            end
            ST_WB: begin
                if (r_wait_cnt != 4'd0) begin
                    memRDEN2 = 1'b1;
                end else begin
                    regWrite   = 1'b1;
                    pcWrite    = 1'b1;
                    w_complete = 1'b1;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pcWrite   = 1'b1;
            end
            default: begin end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_wait_cnt <= 4'd0;
            r_instret  <= '0;
        end else begin
            if (w_complete) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                ST_INIT:  r_state <= ST_FETCH;
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (ir6_0 == c_op_load) begin
                        r_wait_cnt <= c_wait_load;
                        r_state    <= ST_WB;
                    end else begin
                        r_state <= w_irq ? ST_INTR : ST_FETCH;
                    end
                end
                ST_WB: begin
                    // Interrupts are only sampled on the final writeback cycle.
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_state <= w_irq ? ST_INTR : ST_FETCH;
                    end
                end
                ST_INTR:  r_state <= ST_FETCH;
                default:  r_state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_otter_cu_fsm
// Self-checking bench for otter_cu_fsm: vector table, directed corner cases
// and randomized instruction streams against a per-instruction cycle model.
// Rev    : 1.0
// ============================================================================
module tb_otter_cu_fsm;

    localparam int ML0 = 1;
    localparam int ML1 = 3;

    // Output bundle bit order: pcWrite regWrite memWE2 memRDEN1 memRDEN2 rst csr_WE int_taken mret_exec
    localparam logic [8:0] V_PC   = 9'b100000000;
    localparam logic [8:0] V_RW   = 9'b010000000;
    localparam logic [8:0] V_WE   = 9'b001000000;
    localparam logic [8:0] V_RD1  = 9'b000100000;
    localparam logic [8:0] V_RD2  = 9'b000010000;
    localparam logic [8:0] V_RST  = 9'b000001000;
    localparam logic [8:0] V_CSR  = 9'b000000100;
    localparam logic [8:0] V_INT  = 9'b000000010;
    localparam logic [8:0] V_MRET = 9'b000000001;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [8:0] exp_exec;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic [6:0] op0 = '0, op1 = '0;
    logic [2:0] f30 = '0, f31 = '0;
    logic       intr0 = 1'b0, intr1 = 1'b0, mie0 = 1'b0, mie1 = 1'b0;
    logic [8:0] out0, out1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt0 = 0;
    int unsigned exp_cnt1 = 0;

    otter_cu_fsm #(.MEM_LAT(ML0), .CNT_W(32)) u_dut0 (
        .CLK(CLK), .RST(rst0), .ir6_0(op0), .ir14_12(f30), .intr(intr0), .csr_mie(mie0),
        .pcWrite(out0[8]), .regWrite(out0[7]), .memWE2(out0[6]), .memRDEN1(out0[5]),
        .memRDEN2(out0[4]), .rst(out0[3]), .csr_WE(out0[2]), .int_taken(out0[1]),
        .mret_exec(out0[0]), .instret(cnt0)
    );

    otter_cu_fsm #(.MEM_LAT(ML1), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .RST(rst1), .ir6_0(op1), .ir14_12(f31), .intr(intr1), .csr_mie(mie1),
        .pcWrite(out1[8]), .regWrite(out1[7]), .memWE2(out1[6]), .memRDEN1(out1[5]),
        .memRDEN2(out1[4]), .rst(out1[3]), .csr_WE(out1[2]), .int_taken(out1[1]),
        .mret_exec(out1[0]), .instret(cnt1)
    );

    function automatic logic [8:0] outs(input int d);
        return (d == 0) ? out0 : out1;
    endfunction

    // Reference: strobes of the execute cycle, straight from the opcode table.
    function automatic logic [8:0] exec_model(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return V_RD2;
            7'b0100011: return V_PC | V_WE;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return V_PC | V_RW;
            7'b1110011: begin
                if (f3 == 3'b001) return V_PC | V_RW | V_CSR;
                if (f3 == 3'b000) return V_PC | V_MRET;
                return V_PC;
            end
            default: return V_PC;
        endcase
    endfunction

    task automatic set_in(input int d, input logic [6:0] op, input logic [2:0] f3,
                          input logic i, input logic m);
        if (d == 0) begin op0 = op; f30 = f3; intr0 = i; mie0 = m; end
        else        begin op1 = op; f31 = f3; intr1 = i; mie1 = m; end
    endtask

    task automatic set_irq(input int d, input logic i, input logic m);
        if (d == 0) begin intr0 = i; mie0 = m; end
        else        begin intr1 = i; mie1 = m; end
    endtask

    task automatic check_out(input string nm, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_cnt(input int d, input string nm);
        checks++;
        if (d == 0) begin
            if (cnt0 !== exp_cnt0) begin
                errors++;
                $display("FAIL %s_instret0: got %0d required %0d at %0t", nm, cnt0, exp_cnt0, $time);
            end
        end else begin
            if (cnt1 !== exp_cnt1[3:0]) begin
                errors++;
                $display("FAIL %s_instret1: got %0d required %0d at %0t", nm, cnt1, exp_cnt1[3:0], $time);
            end
        end
    endtask

    // Inputs are already driven at posedge+1; sample at the falling edge.
    task automatic cyc(input int d, input logic [8:0] exp, input string nm);
        #4;
        check_out(nm, outs(d), exp);
        check_cnt(d, nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic bump(input int d);
        if (d == 0) exp_cnt0 = exp_cnt0 + 1;
        else        exp_cnt1 = exp_cnt1 + 1;
    endtask

    task automatic do_reset(input int d);
        if (d == 0) begin rst0 = 1'b1; exp_cnt0 = 0; end
        else        begin rst1 = 1'b1; exp_cnt1 = 0; end
        repeat (3) begin
            #4;
            check_out("reset_out", outs(d) & ~V_RST, 9'b0);
            check_cnt(d, "reset");
            @(posedge CLK);
            #1;
        end
        if (d == 0) rst0 = 1'b0;
        else        rst1 = 1'b0;
        cyc(d, V_RST, "init");
    endtask

    // One instruction from fetch to completion, plus interrupt entry when the
    // completion cycle sees intr & csr_mie.
    task automatic run_instr(input int d, input logic [6:0] op, input logic [2:0] f3,
                             input logic [8:0] exp_exec, input bit rnd,
                             input logic gi, input logic gm);
        int   nwb;
        logic fi, fm;
        nwb = (op == OP_LW) ? ((d == 0) ? ML0 : ML1) : 0;
        fi  = rnd ? 1'($urandom_range(0, 1)) : gi;
        fm  = rnd ? 1'($urandom_range(0, 1)) : gm;
        set_in(d, op, f3, fi, fm);
        cyc(d, V_RD1, "fetch");
        if (rnd) begin fi = 1'($urandom_range(0, 1)); fm = 1'($urandom_range(0, 1)); end
        set_irq(d, fi, fm);
        cyc(d, exp_exec, "exec");
        for (int k = 1; k <= nwb; k++) begin
            if (rnd) begin fi = 1'($urandom_range(0, 1)); fm = 1'($urandom_range(0, 1)); end
            set_irq(d, fi, fm);
            cyc(d, (k < nwb) ? V_RD2 : (V_PC | V_RW), "wb");
        end
        bump(d);
        if (fi & fm) begin
            if (rnd) set_irq(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc(d, V_PC | V_INT, "intr");
        end
    endtask

    task automatic run_random(input int d, input int n);
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [2:0] f3;
        int         sel;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 11));
            op  = (sel < 10) ? ops[sel] : 7'($urandom);
            f3  = 3'($urandom_range(0, 7));
            run_instr(d, op, f3, exec_model(op, f3), 1'b1, 1'b0, 1'b0);
        end
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{7'b0010011, 3'b000, V_PC | V_RW};          // addi
        tbl[1]  = '{7'b0100011, 3'b010, V_PC | V_WE};          // sw
        tbl[2]  = '{7'b1100011, 3'b000, V_PC};                 // beq
        tbl[3]  = '{7'b0110011, 3'b000, V_PC | V_RW};          // add
        tbl[4]  = '{7'b0110111, 3'b101, V_PC | V_RW};          // lui
        tbl[5]  = '{7'b0010111, 3'b011, V_PC | V_RW};          // auipc
        tbl[6]  = '{7'b1101111, 3'b111, V_PC | V_RW};          // jal
        tbl[7]  = '{7'b1100111, 3'b000, V_PC | V_RW};          // jalr
        tbl[8]  = '{7'b1110011, 3'b001, V_PC | V_RW | V_CSR};  // csrrw
        tbl[9]  = '{7'b1110011, 3'b000, V_PC | V_MRET};        // mret
        tbl[10] = '{7'b1110011, 3'b010, V_PC};                 // other system
        tbl[11] = '{7'b1111111, 3'b000, V_PC};                 // illegal
        tbl[12] = '{7'b0000000, 3'b000, V_PC};                 // illegal
        tbl[13] = '{7'b0000011, 3'b010, V_RD2};                // lw

        @(posedge CLK);
        #1;

        // Instance 0: MEM_LAT = 1, 32-bit counter
        do_reset(0);
        for (int i = 0; i < 14; i++)
            run_instr(0, tbl[i].op, tbl[i].f3, tbl[i].exp_exec, 1'b0, 1'b0, 1'b0);
        run_instr(0, 7'b0110011, 3'b000, V_PC | V_RW, 1'b0, 1'b1, 1'b1);   // add + interrupt
        run_instr(0, 7'b0110011, 3'b000, V_PC | V_RW, 1'b0, 1'b1, 1'b0);   // masked
        run_instr(0, 7'b1110011, 3'b000, V_PC | V_MRET, 1'b0, 1'b1, 1'b1); // mret + interrupt
        run_instr(0, OP_LW, 3'b010, V_RD2, 1'b0, 1'b1, 1'b1);              // load + interrupt
        run_random(0, 150);

        // Instance 1: MEM_LAT = 3, 4-bit counter
        do_reset(1);
        run_instr(1, OP_LW, 3'b010, V_RD2, 1'b0, 1'b0, 1'b0);
        // Interrupt visible only before the final writeback cycle is ignored
        set_in(1, OP_LW, 3'b010, 1'b1, 1'b1);
        cyc(1, V_RD1, "lwirq_fetch");
        cyc(1, V_RD2, "lwirq_exec");
        cyc(1, V_RD2, "lwirq_wb1");
        cyc(1, V_RD2, "lwirq_wb2");
        set_irq(1, 1'b0, 1'b1);
        cyc(1, V_PC | V_RW, "lwirq_wb3");
        bump(1);
        cyc(1, V_RD1, "lwirq_nointr");
        cyc(1, V_RD2, "lwirq_exec2");
        set_irq(1, 1'b0, 1'b0);
        for (int k = 1; k <= ML1; k++)
            cyc(1, (k < ML1) ? V_RD2 : (V_PC | V_RW), "lwirq_wbb");
        bump(1);
        run_random(1, 60);

        // Counter wrap at 2^4
        while (exp_cnt1[3:0] != 4'hF)
            run_instr(1, OP_ADDI, 3'b000, V_PC | V_RW, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt1 !== 4'hF) begin
            errors++;
            $display("FAIL wrap_pre: got %0d required 15", cnt1);
        end
        run_instr(1, OP_ADDI, 3'b000, V_PC | V_RW, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt1 !== 4'h0) begin
            errors++;
            $display("FAIL wrap_post: got %0d required 0", cnt1);
        end
        run_instr(1, OP_ADDI, 3'b000, V_PC | V_RW, 1'b0, 1'b0, 1'b0);
        run_instr(1, OP_ADDI, 3'b000, V_PC | V_RW, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset on the second writeback cycle of a load
        set_in(1, OP_LW, 3'b010, 1'b0, 1'b0);
        cyc(1, V_RD1, "abort_fetch");
        cyc(1, V_RD2, "abort_exec");
        cyc(1, V_RD2, "abort_wb1");
        rst1     = 1'b1;
        exp_cnt1 = 0;
        #3;
        check_out("abort_async", outs(1) & ~V_RST, 9'b0);
        check_cnt(1, "abort_async");
        @(posedge CLK);
        #1;
        check_out("abort_hold", outs(1) & ~V_RST, 9'b0);
        check_cnt(1, "abort_hold");
        @(posedge CLK);
        #1;
        rst1 = 1'b0;
        cyc(1, V_RST, "abort_init");
        run_instr(1, OP_ADDI, 3'b000, V_PC | V_RW, 1'b0, 1'b0, 1'b0);
        run_instr(1, OP_LW, 3'b010, V_RD2, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
